// File: rtl/srrc_tx_flt_interp.sv
// 4-ary PAM mapper with a 4x interpolating 17-tap SRRC polyphase pulse shaper.
// Optional SRRC_TX_UNDERRUN_CNT_EN adds a saturating underrun event counter.
module srrc_tx_flt_interp #(
    parameter int OSR       = 4,
    parameter int OUT_SHIFT = 2,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [1:0]              sym_in,
    input  logic                    sym_valid,
    output logic                    sym_ready,
    output logic signed [17:0]      out,
    output logic                    out_valid,
    output logic [1:0]              out_phase,
    output logic                    underrun,
    output logic [CNT_W-1:0]        underrun_cnt
);

    localparam int ACC_W = 24;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                   state;
    logic [1:0]               ph;
    logic [2:0]               zcnt;
    logic signed [2:0]        a [5];
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [17:0]       sat_out;
    logic                     last_ph;
    logic                     accept;
    logic                     ins_zero;
    logic signed [2:0]        shift_lvl;

    // Gray-coded symbol to level: 00->-3, 01->-1, 11->+1, 10->+3.
    function automatic logic signed [2:0] map_sym(input logic [1:0] s);
        logic signed [2:0] l;
        case (s)
            2'b00:   l = 3'b101;
            2'b01:   l = 3'b111;
            2'b11:   l = 3'b001;
            default: l = 3'b011;
        endcase
        return l;
    endfunction

    // Only the lower half of the symmetric impulse response is stored.
    function automatic logic signed [17:0] coef(input int k);
        logic signed [17:0] c;
        case ((k > 8) ? 16 - k : k)
            0:       c = 18'sd314;
            1:       c = -18'sd2115;
            2:       c = -18'sd5743;
            3:       c = -18'sd6936;
            4:       c = -18'sd719;
            5:       c = 18'sd15367;
            6:       c = 18'sd37897;
            7:       c = 18'sd57966;
            default: c = 18'sd66023;
        endcase
        return c;
    endfunction

    function automatic logic signed [ACC_W-1:0] mul_lvl(input logic signed [17:0] c,
                                                       input logic signed [2:0]  lvl);
        logic signed [ACC_W-1:0] ce;
        logic signed [ACC_W-1:0] mag;
        ce = {{(ACC_W-18){c[17]}}, c};
        case (lvl)
            3'b011, 3'b101: mag = (ce <<< 1) + ce;
            3'b001, 3'b111: mag = ce;
            default:        mag = '0;
        endcase
        return lvl[2] ? -mag : mag;
    endfunction

    assign last_ph   = (ph == 2'(OSR - 1));
    assign sym_ready = (state == IDLE) || last_ph;
    assign accept    = sym_valid && sym_ready;
    assign ins_zero  = (state == RUN) && last_ph && !sym_valid;
    assign shift_lvl = sym_valid ? map_sym(sym_in) : 3'sd0;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        acc = '0;
        for (int j = 0; j < 5; j++) begin
            if (4 * j + int'(ph) <= 16)
                acc = acc + mul_lvl(coef(4 * j + int'(ph)), a[j]);
        end
        shifted = acc >>> OUT_SHIFT;
        if (shifted > ACC_W'(131071))
            sat_out = 18'sd131071;
        else if (shifted < -ACC_W'(131072))
            sat_out = -18'sd131072;
        else
            sat_out = shifted[17:0];
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ph        <= 2'(OSR - 1);
            zcnt      <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            out_phase <= '0;
            underrun  <= 1'b0;
            // NOTE: the delay line is only five levels deep, so it is reset along with the control state.
            for (int i = 0; i < 5; i++) a[i] <= '0;
        end else begin
            underrun <= 1'b0;
            case (state)
                IDLE: begin
                    out       <= '0;
                    out_valid <= 1'b0;
                    if (sym_valid) begin
                        for (int i = 4; i > 0; i--) a[i] <= a[i-1];
                        a[0]  <= map_sym(sym_in);
                        ph    <= '0;
                        zcnt  <= '0;
                        state <= RUN;
                    end
                end
                default: begin
                    ph        <= ph + 2'd1;
                    out       <= sat_out;
                    out_phase <= ph;
                    out_valid <= 1'b1;
                    if (last_ph) begin
                        for (int i = 4; i > 0; i--) a[i] <= a[i-1];
                        a[0] <= shift_lvl;
                        if (accept) begin
                            zcnt <= '0;
                        end else begin
                            underrun <= 1'b1;
                            zcnt     <= zcnt + 3'd1;
                            // Fifth consecutive zero flushes the last symbol out of the line.
                            if (zcnt == 3'd4) begin
                                state     <= IDLE;
                                ph        <= 2'(OSR - 1);
                                out       <= '0;
                                out_valid <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

`ifdef SRRC_TX_UNDERRUN_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else if (ins_zero && (cnt_q != '1))
            cnt_q <= cnt_q + 1'b1;
    end

    assign underrun_cnt = cnt_q;
`else
    assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_srrc_tx_flt_interp.sv
// Scoreboard bench for srrc_tx_flt_interp: a direct-form convolution model queues expected
// samples, a negedge monitor pops and compares; hand-computed values anchor the key responses.
module tb_srrc_tx_flt_interp;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [1:0]         sym_in = 2'b00;
    logic               sym_valid = 1'b0;
    logic               sym_ready;
    logic signed [17:0] out;
    logic               out_valid;
    logic [1:0]         out_phase;
    logic               underrun;
    logic [15:0]        underrun_cnt;

    srrc_tx_flt_interp #(.OSR(4), .OUT_SHIFT(2), .CNT_W(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sym_in       (sym_in),
        .sym_valid    (sym_valid),
        .sym_ready    (sym_ready),
        .out          (out),
        .out_valid    (out_valid),
        .out_phase    (out_phase),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    localparam int H [17] = '{314, -2115, -5743, -6936, -719, 15367, 37897, 57966, 66023,
                              57966, 37897, 15367, -719, -6936, -5743, -2115, 314};

    typedef struct {
        int val;
        int ph;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    int   log_q[$];
    exp_t e;

    bit m_run = 1'b0;
    int m_ph = 3;
    int m_zcnt = 0;
    int pend = 0;
    int xs [17];
    int obs_under = 0;
    int under_since_rst = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lvl(input logic [1:0] s);
        case (s)
            2'b00:   return -3;
            2'b01:   return -1;
            2'b11:   return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int sat18(input int v);
        if (v > 131071) return 131071;
        if (v < -131072) return -131072;
        return v;
    endfunction

    function automatic int log_at(input int i);
        if (i < log_q.size()) return log_q[i];
        return -999999;
    endfunction

    // Reference model: upsampled symbol stream convolved with the full 17-tap response.
    always @(posedge clk or negedge reset_n) begin : model
        bit emit;
        int acc;
        if (!reset_n) begin
            m_run = 1'b0;
            m_ph = 3;
            m_zcnt = 0;
            pend = 0;
            for (int k = 0; k < 17; k++) xs[k] = 0;
            q.delete();
            under_since_rst = 0;
        end else if (!m_run) begin
            if (sym_valid) begin
                pend = lvl(sym_in);
                m_run = 1'b1;
                m_ph = 0;
                m_zcnt = 0;
            end
        end else begin
            for (int k = 16; k > 0; k--) xs[k] = xs[k-1];
            xs[0] = pend;
            pend = 0;
            acc = 0;
            for (int k = 0; k < 17; k++) acc += H[k] * xs[k];
            emit = 1'b1;
            if (m_ph == 3) begin
                if (sym_valid) begin
                    pend = lvl(sym_in);
                    m_zcnt = 0;
                end else begin
                    m_zcnt++;
                    under_since_rst++;
                    if (m_zcnt == 5) begin
                        m_run = 1'b0;
                        emit = 1'b0;
                    end
                end
            end
            if (emit) q.push_back('{sat18(acc >>> 2), m_ph});
            m_ph = (m_ph + 1) % 4;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            check("sym_ready", int'(sym_ready), int'(!m_run || m_ph == 3));
            if (underrun) obs_under++;
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sample: got %0d, expected no sample (t=%0t)", out, $time);
                end else begin
                    e = q.pop_front();
                    check("out", int'(out), e.val);
                    check("out_phase", int'(out_phase), e.ph);
                    log_q.push_back(int'(out));
                end
            end
        end
    end

    task automatic put_sym(input logic [1:0] s);
        int n;
        @(negedge clk);
        sym_valid = 1'b1;
        sym_in = s;
        n = 0;
        while (!sym_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", int'(sym_ready), 1);
        @(posedge clk);
    endtask

    task automatic gap_slot();
        int n;
        @(negedge clk);
        sym_valid = 1'b0;
        n = 0;
        while (!sym_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("gap_wait", int'(sym_ready), 1);
        @(posedge clk);
    endtask

    task automatic wait_flush();
        int n;
        @(negedge clk);
        sym_valid = 1'b0;
        repeat (2) @(negedge clk);
        n = 0;
        while (out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("flush_done", int'(out_valid), 0);
        repeat (2) @(negedge clk);
        check("queue_empty", q.size(), 0);
    endtask

    task automatic check_cnt(input string name);
`ifdef SRRC_TX_UNDERRUN_CNT_EN
        check(name, int'(underrun_cnt), under_since_rst);
`else
        check(name, int'(underrun_cnt), 0);
`endif
    endtask

    task automatic check_single(input string tag);
        check({tag, "_len"}, log_q.size(), 19);
        check({tag, "_k0"}, log_at(0), 235);
        check({tag, "_k1"}, log_at(1), -1587);
        check({tag, "_k8"}, log_at(8), 49517);
        check({tag, "_k16"}, log_at(16), 235);
        check({tag, "_k17"}, log_at(17), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int base;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out", int'(out), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_phase", int'(out_phase), 0);
        check("rst_underrun", int'(underrun), 0);
        check("rst_cnt", int'(underrun_cnt), 0);
        reset_n = 1'b1;

        // Idle with no symbols offered.
        repeat (20) begin
            @(negedge clk);
            check("idle_out", int'(out), 0);
            check("idle_out_valid", int'(out_valid), 0);
        end
        check("idle_underruns", obs_under, 0);

        // Single +3 symbol followed by flush.
        log_q.delete();
        base = obs_under;
        put_sym(2'b10);
        wait_flush();
        check_single("single");
        check("single_underruns", obs_under - base, 5);
        check_cnt("single_cnt");

        // Continuous -1 stream: steady-state per-phase sums.
        log_q.delete();
        base = obs_under;
        for (int i = 0; i < 10; i++) put_sym(2'b01);
        wait_flush();
        check("stream_len", log_q.size(), 55);
        check("stream_ph0", log_at(20), -16304);
        check("stream_ph1", log_at(21), -16071);
        check("stream_ph2", log_at(22), -16077);
        check("stream_ph3", log_at(23), -16071);
        check("stream_underruns", obs_under - base, 5);
        check_cnt("stream_cnt");

        // Three -3 symbols, one empty slot, then +1: a single mid-stream underrun.
        log_q.delete();
        base = obs_under;
        for (int i = 0; i < 3; i++) put_sym(2'b00);
        gap_slot();
        put_sym(2'b11);
        @(negedge clk);
        check("gap_underruns", obs_under - base, 1);
        check("gap_still_run", int'(out_valid), 1);
        wait_flush();
        check("gap_total_underruns", obs_under - base, 6);
        check_cnt("gap_cnt");

        // Asynchronous reset while an underrun pulse is on the outputs.
        put_sym(2'b10);
        @(negedge clk);
        sym_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("pre_rst_underrun", int'(underrun), 1);
        check("pre_rst_out_valid", int'(out_valid), 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_out", int'(out), 0);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_underrun", int'(underrun), 0);
        check("mid_rst_cnt", int'(underrun_cnt), 0);
        repeat (2) @(negedge clk);
        #1;
        reset_n = 1'b1;
        log_q.delete();
        base = obs_under;
        put_sym(2'b10);
        wait_flush();
        check_single("post_rst");
        check("post_rst_underruns", obs_under - base, 5);
        check_cnt("post_rst_cnt");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
